// File: rtl/clock_div_prog_if.sv
// clock_div_prog_if: control and status bundle for the programmable clock divider
interface clock_div_prog_if #(parameter int WIDTH = 17);
  logic enable;
  logic load;
  logic [WIDTH-1:0] div_value;
  logic div_clock;
  logic tick;
  logic load_busy;
  logic running;
  modport master (output enable, load, div_value, input div_clock, tick, load_busy, running);
  modport slave (input enable, load, div_value, output div_clock, tick, load_busy, running);
endinterface

// File: rtl/clock_div_prog.sv
// clock_div_prog: synchronous programmable divider with boundary-aligned reload and stop
module clock_div_prog #(
  parameter int WIDTH = 17,
  parameter int DEFAULT_DIV = 131072
) (
  input logic clock,
  input logic reset,
  clock_div_prog_if.slave bus
);
  typedef enum logic {STOP, RUN} state_t;
  localparam logic [63:0] div_max = {{(64-WIDTH){1'b0}}, {WIDTH{1'b1}}};
  localparam logic [63:0] div_req = 64'(DEFAULT_DIV);
  localparam logic [63:0] div_sat = div_req > div_max ? div_max : div_req;
  localparam logic [WIDTH-1:0] reset_div = div_sat < 64'd2 ? WIDTH'(2) : div_sat[WIDTH-1:0];
  function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] v);
    return v < WIDTH'(2) ? WIDTH'(2) : v;
  endfunction
  state_t state, state_n;
  logic [WIDTH-1:0] cnt, cnt_n, a, a_n, p, p_n, load_val, next_div, cnt_inc;
  logic busy, busy_n, dclk, dclk_n, tick_r, tick_n, boundary;
  assign load_val = clamp(bus.div_value);
  assign boundary = cnt == a - WIDTH'(1);
  assign cnt_inc = cnt + WIDTH'(1);
  assign next_div = bus.load ? load_val : busy ? p : a;
  assign bus.div_clock = dclk;
  assign bus.tick = tick_r;
  assign bus.load_busy = busy;
  assign bus.running = state == RUN;
  // state register; reset aborts any period and drops the pending divisor
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= STOP;
      cnt <= '0;
      a <= reset_div;
      p <= '0;
      busy <= 1'b0;
      dclk <= 1'b0;
      tick_r <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      a <= a_n;
      p <= p_n;
      busy <= busy_n;
      dclk <= dclk_n;
      tick_r <= tick_n;
    end
  // next state: loads apply at once in STOP, otherwise wait for the period boundary
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    a_n = a;
    p_n = p;
    busy_n = busy;
    dclk_n = dclk;
    tick_n = tick_r;
    if (state == STOP) begin
      a_n = bus.load ? load_val : a;
      state_n = bus.enable ? RUN : STOP;
      cnt_n = '0;
      dclk_n = bus.enable;
      tick_n = bus.enable;
    end else if (!boundary) begin
      cnt_n = cnt_inc;
      tick_n = 1'b0;
      dclk_n = cnt_inc < (a >> 1);
      p_n = bus.load ? load_val : p;
      busy_n = busy | bus.load;
    end else begin
      a_n = next_div;
      busy_n = 1'b0;
      cnt_n = '0;
      state_n = bus.enable ? RUN : STOP;
      dclk_n = bus.enable;
      tick_n = bus.enable;
    end
  end
endmodule
